register_sequencer: RTL
=======================

# register_sequencer

Instruction fetch/execute engine that drives the instruction memory's read address and consumes the 32-bit instruction words it returns. Each word is decoded as NOP, WRITE or READ toward the accelerometer bus master; READ results are forwarded to the display path. It sits between the instruction memory and the serial bus master. It runs one program from address 0 per `start` pulse.

## Interface
Parameters:
- `MEMORY_SIZE`, default 255: index of the last valid instruction address.
- `ADDR_W`, default 8: instruction address width, equal to clog2(MEMORY_SIZE+1).
- `TIMEOUT_CYCLES`, default 1024: maximum cycles to wait for a bus response.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle pulse; begins a program run from address 0.
- `instr_addr`  out  ADDR_W  registered read address to the instruction memory.
- `instr_data`  in  32  instruction word; valid 1 cycle after `instr_addr` changes.
- `instr_err`  in  4  memory error code; nonzero means fault.
- `bus_req_valid`  out  1  bus request valid.
- `bus_req_ready`  in  1  bus master accepts the request.
- `bus_req_write`  out  1  1 = write, 0 = read.
- `bus_req_addr`  out  8  device register address.
- `bus_req_wdata`  out  8  write data.
- `bus_rsp_valid`  in  1  single-cycle completion pulse from the bus master.
- `bus_rsp_rdata`  in  8  read data; valid with `bus_rsp_valid`.
- `rd_data`  out  8  last READ result.
- `rd_valid`  out  1  1-cycle pulse when `rd_data` updates.
- `busy`  out  1  high in any state other than IDLE.
- `error_code`  out  4  sticky error code; cleared on `start`.

## Operation
- Instruction fields:
  - [31:24] opcode: 0x00 NOP, 0x01 WRITE, 0x02 READ, 0x03 HALT; any other value is illegal.
  - [23:16] device register address.
  - [15:8] write data.
  - [7:0] reserved, ignored.
- Reset values: all outputs 0; state IDLE; pc 0. Reset mid-run aborts the run immediately; no bus request persists.
- States and transitions:
  - IDLE: on `start`, set pc=0, set `instr_addr`=0, clear `error_code`, go to FETCH.
  - FETCH: one wait cycle for the memory read latency.
  - DECODE: sample `instr_data` and `instr_err`.
    - `instr_err`≠0: `error_code`=4, go to IDLE.
    - NOP: advance.
    - HALT: go to IDLE with `error_code` unchanged (0).
    - WRITE/READ: load the bus_req fields, go to REQ.
    - Illegal opcode: `error_code`=1, go to IDLE.
  - REQ: hold `bus_req_valid`=1 with fields stable until `bus_req_ready`; on handshake, go to RSP.
  - RSP: wait for `bus_rsp_valid`.
    - On READ completion, register `rd_data`=`bus_rsp_rdata` and pulse `rd_valid`.
    - Then advance.
    - If the response is missing after TIMEOUT_CYCLES cycles in RSP: `error_code`=2, go to IDLE.
- Advance:
  - If pc==MEMORY_SIZE: `error_code`=3 (ran off the end without HALT), go to IDLE.
  - Otherwise pc+1, `instr_addr`=pc+1, go to FETCH.
- `start` outside IDLE is ignored.
- `bus_rsp_valid` outside RSP is ignored.
- `bus_req_ready` with `bus_req_valid` low has no effect.

## Timing
- `start` sampled at edge 0. Edge 1: `instr_addr`=0 and state is FETCH. Edge 2: state is DECODE, so `instr_data` is stable when DECODE samples it.
- NOP cost: 2 cycles (FETCH, DECODE).
- WRITE/READ cost: 2 cycles + REQ cycles (≥1) + RSP cycles (≥1).
- `bus_req_valid` rises the edge after DECODE and falls the edge after the ready handshake.
- `rd_valid` and `rd_data` update on the edge after `bus_rsp_valid` is sampled.
- Error transitions take effect on the same edge as the failing decision. `busy` drops on that edge.
- The timeout counter resets on entry to RSP. Error fires when the count reaches TIMEOUT_CYCLES-1 with no response. A response in that same cycle wins over the timeout.

## Structure
- Shared package `reg_seq_pkg` holds:
  - opcode enum (NOP/WRITE/READ/HALT)
  - error code constants (0 none, 1 illegal opcode, 2 timeout, 3 address overflow, 4 memory fault)
  - instruction field bit positions
  - state enum
- The instruction memory also imports this package so that encodings match.
- Single flat module; the timeout counter is inline, with no sub-module.

## Test plan
- Program {READ 0x32, HALT}, `bus_rsp_rdata`=0xA5 after 3 cycles → one request with `bus_req_write`=0 and `bus_req_addr`=0x32; `rd_data`=0xA5 with a 1-cycle `rd_valid`; `busy` falls; `error_code`=0.
- WRITE 0x2D data 0x08 with `bus_req_ready` held low 5 cycles → valid and fields stable all 5 cycles; exactly one handshake; then HALT.
- Opcode 0x07 at address 2 → `error_code`=1, no bus request for that word, IDLE.
- READ with no response → `error_code`=2 after exactly TIMEOUT_CYCLES cycles in RSP; a response on the last cycle instead → no error.
- MEMORY_SIZE=3, all NOPs → addresses 0..3 fetched in order, `error_code`=3; `reset` asserted during REQ → `bus_req_valid`=0 immediately, all outputs 0.

Source files
------------

// File: rtl/reg_seq_pkg.sv
// Shared encodings for the register sequencer and the instruction memory image.
package reg_seq_pkg;

    typedef enum logic [7:0] {
        OP_NOP   = 8'h00,
        OP_WRITE = 8'h01,
        OP_READ  = 8'h02,
        OP_HALT  = 8'h03
    } opcode_e;

    localparam logic [3:0] ERR_NONE      = 4'd0;
    localparam logic [3:0] ERR_ILLEGAL   = 4'd1;
    localparam logic [3:0] ERR_TIMEOUT   = 4'd2;
    localparam logic [3:0] ERR_OVERFLOW  = 4'd3;
    localparam logic [3:0] ERR_MEM_FAULT = 4'd4;

    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 24;
    localparam int DEV_ADDR_MSB = 23;
    localparam int DEV_ADDR_LSB = 16;
    localparam int WDATA_MSB    = 15;
    localparam int WDATA_LSB    = 8;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_REQ    = 3'd3;
    localparam state_t ST_RSP    = 3'd4;

    function automatic logic [31:0] make_instr(opcode_e op, logic [7:0] dev_addr, logic [7:0] wdata);
        return {op, dev_addr, wdata, 8'h00};
    endfunction

endpackage

// File: rtl/register_sequencer.sv
// Fetches 32-bit instructions from address 0 per start pulse and issues
// WRITE/READ transactions to the accelerometer bus master.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | one-cycle memory read latency
// DECODE | sample instruction word and memory error
// REQ    | bus request held until ready
// RSP    | waiting for bus response, timeout down-counter running
module register_sequencer
    import reg_seq_pkg::*;
#(
    parameter int MEMORY_SIZE    = 255,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [31:0]       instr_data,
    input  logic [3:0]        instr_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_req_write,
    output logic [7:0]        bus_req_addr,
    output logic [7:0]        bus_req_wdata,
    input  logic              bus_rsp_valid,
    input  logic [7:0]        bus_rsp_rdata,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic [3:0]        error_code
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEMORY_SIZE);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [TO_W-1:0]   to_count;
    logic [7:0]        opcode;
    logic              at_last;
    logic              unused_reserved;

    assign opcode          = instr_data[OPCODE_MSB:OPCODE_LSB];
    assign unused_reserved = ^instr_data[7:0];
    assign at_last         = (pc == LAST_ADDR);
    assign instr_addr      = pc;
    assign busy            = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            pc            <= '0;
            to_count      <= '0;
            bus_req_valid <= 1'b0;
            bus_req_write <= 1'b0;
            bus_req_addr  <= 8'h00;
            bus_req_wdata <= 8'h00;
            rd_data       <= 8'h00;
            rd_valid      <= 1'b0;
            error_code    <= ERR_NONE;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc         <= '0;
                        error_code <= ERR_NONE;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    if (instr_err != 4'd0) begin
                        error_code <= ERR_MEM_FAULT;
                        state      <= ST_IDLE;
                    end else begin
                        case (opcode)
                            OP_NOP: begin
                                if (at_last) begin
                                    error_code <= ERR_OVERFLOW;
                                    state      <= ST_IDLE;
                                end else begin
                                    pc    <= pc + 1'b1;
                                    state <= ST_FETCH;
                                end
                            end
                            OP_HALT: state <= ST_IDLE;
                            OP_WRITE, OP_READ: begin
                                bus_req_valid <= 1'b1;
                                bus_req_write <= (opcode == OP_WRITE);
                                bus_req_addr  <= instr_data[DEV_ADDR_MSB:DEV_ADDR_LSB];
                                bus_req_wdata <= instr_data[WDATA_MSB:WDATA_LSB];
                                state         <= ST_REQ;
                            end
                            default: begin
                                error_code <= ERR_ILLEGAL;
                                state      <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        to_count      <= TO_LOAD;
                        state         <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    // A response arriving on the terminal-count cycle takes priority.
                    if (bus_rsp_valid) begin
                        if (!bus_req_write) begin
                            rd_data  <= bus_rsp_rdata;
                            rd_valid <= 1'b1;
                        end
                        if (at_last) begin
                            error_code <= ERR_OVERFLOW;
                            state      <= ST_IDLE;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= ST_FETCH;
                        end
                    end else if (to_count == '0) begin
                        error_code <= ERR_TIMEOUT;
                        state      <= ST_IDLE;
                    end else begin
                        to_count <= to_count - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
